mem_port_arbiter: RTL

Arbitrates one single-ported unified memory between the CPU's instruction-fetch requester and its load/store requester. Each request is captured, issued to the memory with a req/ack handshake, and the read data or write completion is returned to the owning requester. Alternating priority on conflicts guarantees fetch cannot starve. A bounded-wait timeout prevents a dead memory from hanging the core.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   and the load/store requester. A request is granted (combinational pulse),
//   its fields are captured and issued on m_* until m_ack or timeout, and the
//   result is returned to the owner as a one-cycle rvalid pulse.
//
// Handshakes: a requester holds *_req with its fields until it sees *_gnt
//   high in the same cycle; the transfer is accepted on that clock edge.
//   m_req is held with stable m_* fields until the cycle m_ack is high (the
//   transaction completes on that edge) or the wait bound expires.
//
// Ports:
//   clk, nreset                     clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt        fetch request and grant
//   if_rvalid/if_rdata              fetch response
//   d_req/d_we/d_wstrobe/d_addr/d_wdata -> d_gnt   data request and grant
//   d_rvalid/d_rdata                data response (rdata 0 for stores)
//   m_req/m_we/m_wstrobe/m_addr/m_wdata, m_ack/m_rdata   memory port
//   timeout_err                     flags a timed-out response
//   busy                            FSM not idle
module mem_port_arbiter #(
  parameter int          MAX_WAIT     = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrobe,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wstrobe,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        timeout_err,
  output logic        busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic              last_d;    // 1: last winner was data, 0: fetch
  logic              owner_d;   // owner of the in-flight transaction
  logic [WAIT_W-1:0] wait_cnt;  // ISSUE cycles already spent without ack

  logic              arb_ok;
  logic              pick_d;
  logic              timed_out;
  logic              resp_fire;
  logic [31:0]       resp_data;

  always_comb begin
    arb_ok    = nreset && (state != ISSUE);
    // Data wins when alone, or on a conflict when fetch won last time.
    pick_d    = d_req && (!if_req || !last_d);
    d_gnt     = arb_ok && pick_d;
    if_gnt    = arb_ok && if_req && !pick_d;
    // An ack in the final allowed cycle is a success, so ack is tested first.
    timed_out = (state == ISSUE) && !m_ack && (wait_cnt == WAIT_LAST);
    resp_fire = (state == ISSUE) && (m_ack || timed_out);
    if (m_we)
      resp_data = 32'h0;
    else if (m_ack)
      resp_data = m_rdata;
    else
      resp_data = TIMEOUT_DATA;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      owner_d     <= 1'b0;
      wait_cnt    <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_wstrobe   <= 4'h0;
      m_addr      <= 32'h0;
      m_wdata     <= 32'h0;
      if_rvalid   <= 1'b0;
      if_rdata    <= 32'h0;
      d_rvalid    <= 1'b0;
      d_rdata     <= 32'h0;
      timeout_err <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; rdata is zero outside them.
      if_rvalid   <= 1'b0;
      if_rdata    <= 32'h0;
      d_rvalid    <= 1'b0;
      d_rdata     <= 32'h0;
      timeout_err <= 1'b0;

      case (state)
        IDLE, RESP: begin
          if (if_gnt || d_gnt) begin
            state    <= ISSUE;
            owner_d  <= d_gnt;
            last_d   <= d_gnt;
            wait_cnt <= '0;
            m_req    <= 1'b1;
            if (d_gnt) begin
              m_we      <= d_we;
              m_wstrobe <= d_wstrobe;
              m_addr    <= d_addr;
              m_wdata   <= d_wdata;
            end else begin
              m_we      <= 1'b0;
              m_wstrobe <= 4'b1111;
              m_addr    <= if_addr;
              m_wdata   <= 32'h0;
            end
          end else begin
            state <= IDLE;
          end
        end

        ISSUE: begin
          if (resp_fire) begin
            state       <= RESP;
            m_req       <= 1'b0;
            timeout_err <= timed_out;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= resp_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
